// File: rtl/fp_addsub_normalize_round.sv
// Post-execution stage of the single-precision FP add/sub pipeline: normalizes the raw
// mantissa sum, rounds to nearest-even and packs the result. Two stages, valid/ready on both sides.
module fp_addsub_normalize_round (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [25:0] Sum,
  input  logic        PSgn,
  input  logic        Opr,
  input  logic        G,
  input  logic        PS,
  input  logic [7:0]  Exp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Z,
  output logic        Overflow,
  output logic        Underflow
);

  typedef struct packed {
    logic signed [9:0] e;
    logic [23:0]       m;
  } rnd_t;

  // Leading zeros of the 25-bit sum below the carry; 25 when all bits are clear.
  function automatic logic [4:0] lzc25(input logic [24:0] v);
    logic [4:0] n;
    n = 5'd25;
    for (int i = 0; i < 25; i++) begin
      if (v[i]) n = 5'(24 - i);
    end
    return n;
  endfunction

  function automatic rnd_t round_rne(input logic [23:0] m, input logic r, input logic s,
                                     input logic signed [9:0] e);
    logic [24:0] w_sum;
    rnd_t        res;
    w_sum = {1'b0, m} + {24'd0, r & (s | m[0])};
    if (w_sum[24]) begin
      res.m = 24'h800000;
      res.e = e + 10'sd1;
    end else begin
      res.m = w_sum[23:0];
      res.e = e;
    end
    return res;
  endfunction

  // Returns {Overflow, Underflow, Z}; no denormals, exponent overflow saturates to infinity.
  function automatic logic [33:0] pack_sat(input logic sgn, input logic zero, input rnd_t v);
    logic signed [9:0] e;
    logic [22:0]       frac;
    e    = v.e;
    frac = 23'(v.m);
    if (zero)              return {2'b00, 32'h0000_0000};
    if (e <= 10'sd0)       return {2'b01, sgn, 31'd0};
    if (e >= 10'sd255)     return {2'b10, sgn, 8'hFF, 23'd0};
    return {2'b00, sgn, e[7:0], frac};
  endfunction

  logic w_s1_adv;
  logic w_s2_adv;
  logic r_vld_p1;
  logic r_vld_p2;

  assign w_s2_adv  = ~r_vld_p2 | out_ready;
  assign w_s1_adv  = ~r_vld_p1 | w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_vld_p2;

  logic                w_g_eff;
  logic                w_s_eff;
  logic [4:0]          w_lz_p0;
  logic [25:0]         w_shl_p0;
  logic [24:0]         w_shl_mr_p0;
  logic signed [9:0]   w_exp_p0;
  logic [23:0]         w_m_p0;
  logic                w_r_p0;
  logic                w_s_p0;
  logic signed [9:0]   w_e_p0;
  logic                w_zero_p0;

  // On subtraction the execution stage added a conditional +1; XOR with PS undoes it on G.
  assign w_g_eff     = Opr ? (G ^ PS) : G;
  assign w_s_eff     = PS;
  assign w_exp_p0    = $signed({2'b00, Exp});
  assign w_lz_p0     = lzc25(Sum[24:0]);
  assign w_shl_p0    = {Sum[24:0], w_g_eff} << w_lz_p0;
  assign w_shl_mr_p0 = 25'(w_shl_p0 >> 1);
  assign w_zero_p0   = (Sum == 26'd0) & ~w_g_eff & ~w_s_eff;

  always_comb begin
    w_m_p0 = w_shl_mr_p0[24:1];
    w_r_p0 = w_shl_mr_p0[0];
    w_s_p0 = w_s_eff;
    w_e_p0 = w_exp_p0 - $signed({5'd0, w_lz_p0});
    if (Sum[25]) begin
      w_m_p0 = Sum[25:2];
      w_r_p0 = Sum[1];
      w_s_p0 = Sum[0] | w_g_eff | w_s_eff;
      w_e_p0 = w_exp_p0 + 10'sd1;
    end else if (Sum[24]) begin
      w_m_p0 = Sum[24:1];
      w_r_p0 = Sum[0];
      w_s_p0 = w_g_eff | w_s_eff;
      w_e_p0 = w_exp_p0;
    end
  end

  // Stage 1: normalized mantissa, round/sticky bits, signed exponent
  logic [23:0]       r_m_p1;
  logic              r_r_p1;
  logic              r_s_p1;
  logic signed [9:0] r_e_p1;
  logic              r_zero_p1;
  logic              r_sgn_p1;

  always_ff @(posedge clk) begin
    if (rst)           r_vld_p1 <= 1'b0;
    else if (w_s1_adv) r_vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (w_s1_adv && in_valid) begin
      r_m_p1    <= w_m_p0;
      r_r_p1    <= w_r_p0;
      r_s_p1    <= w_s_p0;
      r_e_p1    <= w_e_p0;
      r_zero_p1 <= w_zero_p0;
      r_sgn_p1  <= PSgn;
    end
  end

  rnd_t        w_rnd_p1;
  logic [33:0] w_pack_p1;

  assign w_rnd_p1  = round_rne(r_m_p1, r_r_p1, r_s_p1, r_e_p1);
  assign w_pack_p1 = pack_sat(r_sgn_p1, r_zero_p1, w_rnd_p1);

  // Stage 2: rounded, packed result and per-word flags, held while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2  <= 1'b0;
      Z         <= 32'd0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else if (w_s2_adv) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) {Overflow, Underflow, Z} <= w_pack_p1;
    end
  end

endmodule

// File: tb/tb_fp_addsub_normalize_round.sv
// Bench for fp_addsub_normalize_round: directed vectors, stall/reset scenarios and random traffic
// checked against an arithmetic reference model through an in-order scoreboard.
module tb_fp_addsub_normalize_round;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [25:0] Sum;
  logic        PSgn;
  logic        Opr;
  logic        G;
  logic        PS;
  logic [7:0]  Exp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Z;
  logic        Overflow;
  logic        Underflow;

  fp_addsub_normalize_round dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Sum(Sum), .PSgn(PSgn), .Opr(Opr), .G(G), .PS(PS), .Exp(Exp),
    .out_valid(out_valid), .out_ready(out_ready),
    .Z(Z), .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [33:0] want;
    bit          has_lit;
    logic [33:0] lit;
    int          id;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          next_id = 0;
  bit          cur_lit_en = 1'b0;
  logic [33:0] cur_lit = 34'd0;

  // Reference: returns {Overflow, Underflow, Z} computed with plain integer arithmetic.
  function automatic logic [33:0] ref_model(input logic [25:0] sum, input logic sgn,
                                            input logic opr, input logic g, input logic ps,
                                            input logic [7:0] ex);
    bit     gp, sp, r, s;
    longint t, m;
    int     e, k;
    gp = opr ? (g ^ ps) : g;
    sp = ps;
    if (sum == 26'd0 && !gp && !sp) return 34'd0;
    if (sum[25]) begin
      m = longint'(sum) >> 2; r = sum[1]; s = sum[0] | gp | sp; e = int'(ex) + 1;
    end else if (sum[24]) begin
      m = longint'(sum[24:1]); r = sum[0]; s = gp | sp; e = int'(ex);
    end else begin
      t = (longint'(sum[24:0]) << 1) | longint'(gp);
      k = 0;
      while (k < 25 && t[25] == 1'b0) begin
        t = t << 1;
        k++;
      end
      m = (t >> 2) & 64'hFF_FFFF; r = t[1]; s = sp; e = int'(ex) - k;
    end
    if (r && (s || m[0])) m = m + 1;
    if (m == 64'h100_0000) begin
      m = 64'h80_0000;
      e = e + 1;
    end
    if (e <= 0)   return {2'b01, sgn, 31'd0};
    if (e >= 255) return {2'b10, sgn, 8'hFF, 23'd0};
    return {2'b00, sgn, 8'(e), 23'(m)};
  endfunction

  task automatic chk(input string name, input logic [33:0] got, input logic [33:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // One clock: compare outputs and record accepted inputs at the falling edge, then advance.
  task automatic tick();
    exp_t ent;
    @(negedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 34'(out_valid), 34'd0);
        end else begin
          chk($sformatf("result_%0d", q[0].id), {Overflow, Underflow, Z}, q[0].want);
          if (q[0].has_lit)
            chk($sformatf("literal_%0d", q[0].id), {Overflow, Underflow, Z}, q[0].lit);
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        ent.want    = ref_model(Sum, PSgn, Opr, G, PS, Exp);
        ent.has_lit = cur_lit_en;
        ent.lit     = cur_lit;
        ent.id      = next_id;
        next_id++;
        q.push_back(ent);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [25:0] s, input logic sg, input logic op, input logic g,
                      input logic ps, input logic [7:0] e, input bit lit_en,
                      input logic [33:0] lit);
    bit acc;
    Sum = s; PSgn = sg; Opr = op; G = g; PS = ps; Exp = e;
    in_valid = 1'b1; cur_lit_en = lit_en; cur_lit = lit;
    acc = 1'b0;
    for (int n = 0; n < 100 && !acc; n++) begin
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0; cur_lit_en = 1'b0;
    if (!acc) chk("send_accept_timeout", 34'(acc), 34'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 60 && q.size() != 0; n++) tick();
    chk("drain_empty", 34'(q.size()), 34'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    Sum = '0; PSgn = 1'b0; Opr = 1'b0; G = 1'b0; PS = 1'b0; Exp = '0;
    repeat (3) tick();
    chk("reset_out_valid", 34'(out_valid), 34'd0);
    chk("reset_z_flags", {Overflow, Underflow, Z}, 34'd0);
    rst = 1'b0;
    tick();

    chk("model_pin_k23", ref_model(26'h0000002, 1'b0, 1'b1, 1'b0, 1'b0, 8'd127),
        {2'b00, 32'h3400_0000});
    chk("model_pin_tie_odd", ref_model(26'h1000003, 1'b0, 1'b0, 1'b0, 1'b0, 8'd127),
        {2'b00, 32'h3F80_0002});
    chk("model_pin_ovf", ref_model(26'h3FFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'd254),
        {2'b10, 32'h7F80_0000});

    send(26'h1000000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd127, 1'b1, {2'b00, 32'h3F80_0000});
    send(26'h2000000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd127, 1'b1, {2'b00, 32'h4000_0000});
    send(26'h1000003, 1'b0, 1'b0, 1'b0, 1'b0, 8'd127, 1'b1, {2'b00, 32'h3F80_0002});
    send(26'h1000001, 1'b0, 1'b0, 1'b0, 1'b0, 8'd127, 1'b1, {2'b00, 32'h3F80_0000});
    send(26'h0000000, 1'b1, 1'b1, 1'b0, 1'b0, 8'd127, 1'b1, {2'b00, 32'h0000_0000});
    send(26'h0000002, 1'b0, 1'b1, 1'b0, 1'b0, 8'd127, 1'b1, {2'b00, 32'h3400_0000});
    send(26'h3FFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'd254, 1'b1, {2'b10, 32'h7F80_0000});
    send(26'h0000002, 1'b1, 1'b0, 1'b0, 1'b0, 8'd10,  1'b1, {2'b01, 32'h8000_0000});
    send(26'h0FFFFFE, 1'b0, 1'b1, 1'b1, 1'b0, 8'd127, 1'b1, {2'b00, 32'h3F7F_FFFE});
    drain();

    // Downstream stall: two words fill the pipe, the third must wait.
    out_ready = 1'b0;
    send(26'h1400000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd100, 1'b0, 34'd0);
    send(26'h2800001, 1'b1, 1'b0, 1'b1, 1'b0, 8'd130, 1'b0, 34'd0);
    chk("stall_in_ready_low", 34'(in_ready), 34'd0);
    Sum = 26'h0123456; PSgn = 1'b0; Opr = 1'b1; G = 1'b1; PS = 1'b1; Exp = 8'd90;
    in_valid = 1'b1;
    repeat (4) tick();
    chk("stall_out_valid_held", 34'(out_valid), 34'd1);
    chk("stall_in_ready_still_low", 34'(in_ready), 34'd0);
    out_ready = 1'b1;
    send(26'h0123456, 1'b0, 1'b1, 1'b1, 1'b1, 8'd90, 1'b0, 34'd0);
    drain();

    // Reset while words are stuck in the pipe discards them.
    out_ready = 1'b0;
    send(26'h1800000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd50, 1'b0, 34'd0);
    send(26'h1C00000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd60, 1'b0, 34'd0);
    rst = 1'b1;
    tick();
    chk("rst_clears_out_valid", 34'(out_valid), 34'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("post_rst_idle", 34'(out_valid), 34'd0);

    for (int n = 0; n < 800; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      Sum  = 26'($urandom) >> $urandom_range(0, 25);
      PSgn = 1'($urandom);
      Opr  = 1'($urandom);
      G    = 1'($urandom);
      PS   = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       Exp = 8'($urandom_range(0, 30));
        1:       Exp = 8'($urandom_range(230, 255));
        default: Exp = 8'($urandom);
      endcase
      tick();
    end
    in_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
